hyper_evt_ctrl: RTL

- Sits directly downstream of the HyperBus macro and consumes its 4-bit event vector:
  - bit0: RX channel done
  - bit1: TX channel done
  - bit2: HyperBus read EOT
  - bit3: HyperBus write EOT
- Latches events into pending flags, counts them, applies a mask and produces one level interrupt to the SoC event unit.
- Software accesses it through a small cfg register port on sys_clk_i, in the same style as the udma cfg bus.

---
 rtl/hyper_evt_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/hyper_evt_ctrl.sv
// ----------------------------------------------------------------------------
// hyper_evt_ctrl
//   Collects the HyperBus macro event vector into pending flags and saturating
//   counters, masks them into a single level interrupt for the SoC event unit
//   and exposes everything through a small cfg register port.
//
//   Event map: bit0 RX done, bit1 TX done, bit2 read EOT, bit3 write EOT.
//
//   Ports:
//     sys_clk_i, rstn_i        clock, async active-low reset
//     evt_i[NB_EVT-1:0]        event pulses, one count per high cycle
//     cfg_valid_i/cfg_rwn_i    request, 1=read 0=write
//     cfg_addr_i[3:0]          word address
//     cfg_data_i[31:0]         write data
//     cfg_ready_o              access accepted when valid && ready
//     cfg_data_o[31:0]         registered read data, held until next read
//     irq_o                    registered |(pending & mask)
//     evt_any_o                registered |(evt_i & mask)
//
//   Registers: 0x0 STATUS, 0x1 MASK, 0x2 CLEAR (W1C), 0x3..0x6 CNT0..3,
//              0x7 CTRL (bit0 clear-on-read of STATUS), 0x8 TS_RD, 0x9 TS_WR.
//
//   Optional: define HYPER_EVT_TIMESTAMP_EN to add a free-running 32-bit
//   cycle counter captured by evt_i[2] (TS_RD) and evt_i[3] (TS_WR).
//   Without it 0x8/0x9 read 0.
// ----------------------------------------------------------------------------

// Per-event lane: pending flag, overflow flag, saturating counter.
module hyper_evt_lane #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sys_clk_i,
    input  logic                 rstn_i,
    input  logic                 evt_i,
    input  logic                 clr_i,      // clears pending and overflow
    input  logic                 cnt_clr_i,  // counter write-clear
    output logic                 pend_o,
    output logic                 ovf_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic sat_hit;

    // A write-clear in the same cycle counts the event from zero instead,
    // so it can never be a saturation hit.
    assign sat_hit = evt_i && !cnt_clr_i && (cnt_o == CNT_MAX);

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_o <= 1'b0;
            ovf_o  <= 1'b0;
            cnt_o  <= '0;
        end else begin
            // set wins over clear for both flags
            if (evt_i)      pend_o <= 1'b1;
            else if (clr_i) pend_o <= 1'b0;

            if (sat_hit)    ovf_o <= 1'b1;
            else if (clr_i) ovf_o <= 1'b0;

            if (cnt_clr_i)
                cnt_o <= evt_i ? CNT_ONE : '0;
            else if (evt_i && !sat_hit)
                cnt_o <= cnt_o + CNT_ONE;
        end
    end
endmodule

module hyper_evt_ctrl #(
    parameter int NB_EVT    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic              sys_clk_i,
    input  logic              rstn_i,
    input  logic [NB_EVT-1:0] evt_i,
    input  logic              cfg_valid_i,
    input  logic              cfg_rwn_i,
    input  logic [3:0]        cfg_addr_i,
    input  logic [31:0]       cfg_data_i,
    output logic              cfg_ready_o,
    output logic [31:0]       cfg_data_o,
    output logic              irq_o,
    output logic              evt_any_o
);
    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_MASK   = 4'h1;
    localparam logic [3:0] ADDR_CLEAR  = 4'h2;
    localparam logic [3:0] ADDR_CNT0   = 4'h3;
    localparam logic [3:0] ADDR_CTRL   = 4'h7;
`ifdef HYPER_EVT_TIMESTAMP_EN
    localparam logic [3:0] ADDR_TS_RD  = 4'h8;
    localparam logic [3:0] ADDR_TS_WR  = 4'h9;
`endif

    typedef enum logic {ST_IDLE, ST_COMMIT} state_t;

    state_t state_q, state_d;

    logic                             cfg_acc, cfg_rd, cfg_wr, cor_fire;
    logic                             cor_en_q;
    logic [NB_EVT-1:0]                mask_q, pend, ovf, clr, cnt_clr;
    logic [NB_EVT-1:0][CNT_WIDTH-1:0] cnt;
    logic [31:0]                      rdata;
    logic                             unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_data_i[31:NB_EVT];

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign cfg_acc     = cfg_valid_i && cfg_ready_o;
    assign cfg_rd      = cfg_acc && cfg_rwn_i;
    assign cfg_wr      = cfg_acc && !cfg_rwn_i;

    // Clear-on-read commits on the accept edge; the read itself samples the
    // pre-clear value and a same-cycle event still wins inside the lane.
    assign cor_fire = cfg_rd && (cfg_addr_i == ADDR_STATUS) && cor_en_q;

    assign clr = ((cfg_wr && cfg_addr_i == ADDR_CLEAR) ? cfg_data_i[NB_EVT-1:0] : '0)
               | {NB_EVT{cor_fire}};

    // ready/clear-commit sequencer: one stall cycle after a clearing read
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cor_fire) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < NB_EVT; g++) begin : g_lane
        if (g < 4) begin : g_cnt_map
            assign cnt_clr[g] = cfg_wr && (cfg_addr_i == ADDR_CNT0 + 4'(g));
        end else begin : g_cnt_nomap
            assign cnt_clr[g] = 1'b0;
        end

        hyper_evt_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
            .sys_clk_i (sys_clk_i),
            .rstn_i    (rstn_i),
            .evt_i     (evt_i[g]),
            .clr_i     (clr[g]),
            .cnt_clr_i (cnt_clr[g]),
            .pend_o    (pend[g]),
            .ovf_o     (ovf[g]),
            .cnt_o     (cnt[g])
        );
    end

`ifdef HYPER_EVT_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_rd_q, ts_wr_q;

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ts_cnt_q <= '0;
            ts_rd_q  <= '0;
            ts_wr_q  <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (evt_i[2]) ts_rd_q <= ts_cnt_q;
            if (evt_i[3]) ts_wr_q <= ts_cnt_q;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (cfg_addr_i)
            ADDR_STATUS: begin
                rdata[NB_EVT-1:0] = pend;
                rdata[4 +: NB_EVT] = rdata[4 +: NB_EVT] | ovf;
            end
            ADDR_MASK: rdata[NB_EVT-1:0] = mask_q;
            ADDR_CTRL: rdata[0] = cor_en_q;
`ifdef HYPER_EVT_TIMESTAMP_EN
            ADDR_TS_RD: rdata = ts_rd_q;
            ADDR_TS_WR: rdata = ts_wr_q;
`endif
            default: begin
                for (int i = 0; i < NB_EVT && i < 4; i++)
                    if (cfg_addr_i == ADDR_CNT0 + 4'(i))
                        rdata[CNT_WIDTH-1:0] = cnt[i];
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mask_q     <= '0;
            cor_en_q   <= 1'b0;
            cfg_data_o <= '0;
            irq_o      <= 1'b0;
            evt_any_o  <= 1'b0;
        end else begin
            if (cfg_wr && cfg_addr_i == ADDR_MASK) mask_q   <= cfg_data_i[NB_EVT-1:0];
            if (cfg_wr && cfg_addr_i == ADDR_CTRL) cor_en_q <= cfg_data_i[0];
            if (cfg_rd) cfg_data_o <= rdata;
            irq_o     <= |(pend & mask_q);
            evt_any_o <= |(evt_i & mask_q);
        end
    end
endmodule
